// File: rtl/hist_if.sv
// hist_if: sample, command and readout signals of the histogram controller.
// master = stimulus/consumer side, slave = hist_ctrl side.
interface hist_if #(
    parameter int CNT_W = 8
);
    logic [7:0]       sample_in;
    logic             sample_valid;
    logic             sample_ready;
    logic             cmd_start;
    logic             cmd_stop;
    logic             cmd_clear;
    logic             rd_valid;
    logic             rd_ready;
    logic [3:0]       rd_bin;
    logic [CNT_W-1:0] rd_count;
    logic [1:0]       state;
    logic             ovf;

    modport master (
        output sample_in, sample_valid, cmd_start, cmd_stop, cmd_clear, rd_ready,
        input  sample_ready, rd_valid, rd_bin, rd_count, state, ovf
    );

    modport slave (
        input  sample_in, sample_valid, cmd_start, cmd_stop, cmd_clear, rd_ready,
        output sample_ready, rd_valid, rd_bin, rd_count, state, ovf
    );
endinterface

// File: rtl/hist_ctrl.sv
// hist_ctrl: 16-bin histogram of sample_in[7:4] with clear / accumulate / dump
// phases and a sticky overflow flag.
// Build option: define HIST_SAT_EN to make full bins saturate instead of wrap.
module hist_ctrl #(
    parameter int CNT_W = 8
) (
    input logic  clk,
    input logic  rst_n,
    hist_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_ACCUM = 2'd2,
        ST_DUMP  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] bins_r     [16];
    logic [CNT_W-1:0] bins_nxt_s [16];
    logic [3:0]       clr_idx_r;
    logic [3:0]       clr_idx_nxt_s;
    logic [3:0]       rd_bin_r;
    logic [3:0]       rd_bin_nxt_s;
    logic [CNT_W-1:0] rd_count_r;
    logic             rd_valid_r;
    logic             sample_ready_r;
    logic             ovf_r;
    logic             ovf_nxt_s;
    logic             hit_s;
    logic [3:0]       hit_idx_s;

    // Next value of a bin that takes one more hit.
    function automatic logic [CNT_W-1:0] bin_inc(input logic [CNT_W-1:0] v);
`ifdef HIST_SAT_EN
        if (v == CNT_MAX) begin
            bin_inc = CNT_MAX;
        end else begin
            bin_inc = v + CNT_ONE;
        end
`else
        bin_inc = v + CNT_ONE;
`endif
    endfunction

    // Next-state logic: command decode, clear sweep and readout pointer.
    always_comb begin
        state_nxt_s   = state_r;
        clr_idx_nxt_s = 4'd0;
        rd_bin_nxt_s  = 4'd0;
        case (state_r)
            ST_IDLE: begin
                if (bus.cmd_clear) begin
                    state_nxt_s = ST_CLEAR;
                end else if (bus.cmd_start) begin
                    state_nxt_s = ST_ACCUM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                clr_idx_nxt_s = clr_idx_r + 4'd1;
                if (clr_idx_r == 4'd15) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_ACCUM: begin
                if (bus.cmd_stop) begin
                    state_nxt_s = ST_DUMP;
                end else begin
                    state_nxt_s = ST_ACCUM;
                end
            end
            ST_DUMP: begin
                if (bus.rd_ready) begin
                    if (rd_bin_r == 4'd15) begin
                        state_nxt_s  = ST_IDLE;
                        rd_bin_nxt_s = 4'd0;
                    end else begin
                        state_nxt_s  = ST_DUMP;
                        rd_bin_nxt_s = rd_bin_r + 4'd1;
                    end
                end else begin
                    rd_bin_nxt_s = rd_bin_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Next bin contents and overflow flag: clear sweep or one sample hit.
    always_comb begin
        hit_s     = (state_r == ST_ACCUM) && bus.sample_valid;
        hit_idx_s = bus.sample_in[7:4];
        ovf_nxt_s = ovf_r;
        for (int i = 0; i < 16; i++) begin
            bins_nxt_s[i] = bins_r[i];
        end
        if (state_r == ST_CLEAR) begin
            bins_nxt_s[clr_idx_r] = CNT_ZERO;
            ovf_nxt_s             = 1'b0;
        end else if (hit_s) begin
            bins_nxt_s[hit_idx_s] = bin_inc(bins_r[hit_idx_s]);
            if (bins_r[hit_idx_s] == CNT_MAX) begin
                ovf_nxt_s = 1'b1;
            end else begin
                ovf_nxt_s = ovf_r;
            end
        end else begin
            ovf_nxt_s = ovf_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Bin storage, clear index and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                bins_r[i] <= CNT_ZERO;
            end
            clr_idx_r <= 4'd0;
            ovf_r     <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                bins_r[i] <= bins_nxt_s[i];
            end
            clr_idx_r <= clr_idx_nxt_s;
            ovf_r     <= ovf_nxt_s;
        end
    end

    // Registered outputs, computed from next state so they line up with state_r
    // (the readout count includes a hit landing on the same edge as the stop).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_r     <= 1'b0;
            rd_bin_r       <= 4'd0;
            rd_count_r     <= CNT_ZERO;
            sample_ready_r <= 1'b0;
        end else begin
            rd_valid_r     <= (state_nxt_s == ST_DUMP);
            rd_bin_r       <= rd_bin_nxt_s;
            rd_count_r     <= (state_nxt_s == ST_DUMP) ? bins_nxt_s[rd_bin_nxt_s] : CNT_ZERO;
            sample_ready_r <= (state_nxt_s == ST_ACCUM);
        end
    end

    assign bus.state        = state_r;
    assign bus.sample_ready = sample_ready_r;
    assign bus.rd_valid     = rd_valid_r;
    assign bus.rd_bin       = rd_bin_r;
    assign bus.rd_count     = rd_count_r;
    assign bus.ovf          = ovf_r;

endmodule

// File: tb/tb_hist_ctrl.sv
// tb_hist_ctrl: randomized and directed stimulus for hist_ctrl, compared every
// cycle against a behavioural histogram model, plus literal expectations.
module tb_hist_ctrl;
    localparam int CNT_W = 8;
    localparam int MAXC  = 255;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   chk_en   = 1'b0;

    hist_if #(.CNT_W(CNT_W)) bus ();

    hist_ctrl #(.CNT_W(CNT_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 clearing, 2 accumulating, 3 dumping
    int m_bins [16];
    bit m_ovf   = 1'b0;
    int m_mode  = 0;
    int m_clr   = 0;
    int m_ptr   = 0;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_bins[i] = 0;
        m_ovf  = 1'b0;
        m_mode = 0;
        m_clr  = 0;
        m_ptr  = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            case (m_mode)
                0: begin
                    if (bus.cmd_clear) begin
                        m_mode = 1;
                        m_clr  = 16;
                    end else if (bus.cmd_start) begin
                        m_mode = 2;
                    end
                end
                1: begin
                    m_bins[16 - m_clr] = 0;
                    m_ovf = 1'b0;
                    m_clr = m_clr - 1;
                    if (m_clr == 0) m_mode = 0;
                end
                2: begin
                    if (bus.sample_valid) begin
                        int b;
                        b = int'(bus.sample_in) / 16;
                        if (m_bins[b] == MAXC) begin
                            m_ovf = 1'b1;
`ifdef HIST_SAT_EN
                            m_bins[b] = MAXC;
`else
                            m_bins[b] = 0;
`endif
                        end else begin
                            m_bins[b] = m_bins[b] + 1;
                        end
                    end
                    if (bus.cmd_stop) begin
                        m_mode = 3;
                        m_ptr  = 0;
                    end
                end
                default: begin
                    if (bus.rd_ready) begin
                        if (m_ptr == 15) m_mode = 0;
                        else m_ptr = m_ptr + 1;
                    end
                end
            endcase
        end
    end

    // Per-cycle compare of every output against the model.
    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            logic [31:0] e_state, e_rdy, e_val, e_bin, e_cnt, e_ovf;
            e_state = m_mode;
            e_rdy   = (m_mode == 2) ? 1 : 0;
            e_val   = (m_mode == 3) ? 1 : 0;
            e_bin   = (m_mode == 3) ? m_ptr : 0;
            e_cnt   = (m_mode == 3) ? m_bins[m_ptr] : 0;
            e_ovf   = m_ovf;
            n_checks++;
            if ({30'd0, bus.state} !== e_state || {31'd0, bus.sample_ready} !== e_rdy ||
                {31'd0, bus.rd_valid} !== e_val || {28'd0, bus.rd_bin} !== e_bin ||
                {24'd0, bus.rd_count} !== e_cnt || {31'd0, bus.ovf} !== e_ovf) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t got st=%0d rdy=%0d val=%0d bin=%0d cnt=%0d ovf=%0d expected st=%0d rdy=%0d val=%0d bin=%0d cnt=%0d ovf=%0d",
                         $time, bus.state, bus.sample_ready, bus.rd_valid, bus.rd_bin, bus.rd_count, bus.ovf,
                         e_state, e_rdy, e_val, e_bin, e_cnt, e_ovf);
            end
        end
    end

    // Readout transfer log (values seen at the handshake edge).
    int rd_bin_q [$];
    int rd_cnt_q [$];
    always @(posedge clk) begin
        if (rst_n && bus.rd_valid === 1'b1 && bus.rd_ready === 1'b1) begin
            rd_bin_q.push_back(int'(bus.rd_bin));
            rd_cnt_q.push_back(int'(bus.rd_count));
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int got_cnt(input int i);
        if (i < rd_cnt_q.size()) return rd_cnt_q[i];
        return -1;
    endfunction

    task automatic idle_inputs();
        bus.sample_in    = 8'd0;
        bus.sample_valid = 1'b0;
        bus.cmd_start    = 1'b0;
        bus.cmd_stop     = 1'b0;
        bus.cmd_clear    = 1'b0;
        bus.rd_ready     = 1'b0;
    endtask

    task automatic do_clear(input bit with_start);
        int n;
        int guard;
        n = 0;
        guard = 0;
        bus.cmd_clear = 1'b1;
        bus.cmd_start = with_start;
        @(negedge clk);
        bus.cmd_clear = 1'b0;
        bus.cmd_start = 1'b0;
        while (bus.state == 2'd1 && guard < 100) begin
            n++;
            guard++;
            @(negedge clk);
        end
        check("clear_len", n, 16);
        check("clear_end_state", {30'd0, bus.state}, 0);
    endtask

    task automatic pulse_start();
        bus.cmd_start = 1'b1;
        @(negedge clk);
        bus.cmd_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] v);
        bus.sample_valid = 1'b1;
        bus.sample_in    = v;
        @(negedge clk);
        bus.sample_valid = 1'b0;
    endtask

    task automatic stop(input bit with_s, input logic [7:0] v);
        bus.cmd_stop     = 1'b1;
        bus.sample_valid = with_s;
        bus.sample_in    = v;
        @(negedge clk);
        bus.cmd_stop     = 1'b0;
        bus.sample_valid = 1'b0;
    endtask

    task automatic dump(input bit rand_ready);
        int guard;
        int bad_order;
        guard = 0;
        bad_order = 0;
        rd_bin_q.delete();
        rd_cnt_q.delete();
        while (!(rd_bin_q.size() >= 16 && bus.state == 2'd0) && guard < 400) begin
            bus.rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            guard++;
        end
        bus.rd_ready = 1'b0;
        check("dump_words", rd_bin_q.size(), 16);
        for (int i = 0; i < rd_bin_q.size(); i++) if (rd_bin_q[i] != i) bad_order++;
        check("dump_order", bad_order, 0);
        check("dump_rd_valid_low", {31'd0, bus.rd_valid}, 0);
    endtask

    task automatic check_hist(input string name, input int e [16]);
        int bad;
        bad = 0;
        for (int i = 0; i < 16; i++) if (got_cnt(i) != e[i]) bad++;
        check(name, bad, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int e [16];
        int guard;
        idle_inputs();
        #3 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        check("rst_state", {30'd0, bus.state}, 0);
        check("rst_ready", {31'd0, bus.sample_ready}, 0);
        check("rst_valid", {31'd0, bus.rd_valid}, 0);
        check("rst_count", {24'd0, bus.rd_count}, 0);
        check("rst_ovf", {31'd0, bus.ovf}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // clear and empty dump
        do_clear(1'b0);
        pulse_start();
        stop(1'b0, 8'd0);
        dump(1'b0);
        for (int i = 0; i < 16; i++) e[i] = 0;
        check_hist("clear_dump_zero", e);

        // basic histogram
        pulse_start();
        send(8'h05);
        send(8'h13);
        send(8'h1F);
        send(8'hF0);
        stop(1'b0, 8'd0);
        dump(1'b0);
        for (int i = 0; i < 16; i++) e[i] = 0;
        e[0] = 1; e[1] = 2; e[15] = 1;
        check_hist("basic_hist", e);

        // clear+start together: clear wins; stop-cycle sample; random backpressure
        do_clear(1'b1);
        pulse_start();
        stop(1'b1, 8'h20);
        dump(1'b1);
        for (int i = 0; i < 16; i++) e[i] = 0;
        e[2] = 1;
        check_hist("stop_boundary", e);

        // accumulation continues without clear
        pulse_start();
        send(8'h2A);
        stop(1'b0, 8'd0);
        dump(1'b1);
        e[2] = 2;
        check_hist("continue_accum", e);

        // overflow
        do_clear(1'b0);
        pulse_start();
        for (int i = 0; i < 257; i++) send(8'h30);
        stop(1'b0, 8'd0);
        check("ovf_set", {31'd0, bus.ovf}, 1);
        dump(1'b0);
`ifdef HIST_SAT_EN
        check("ovf_bin3", got_cnt(3), 255);
`else
        check("ovf_bin3", got_cnt(3), 1);
`endif
        check("ovf_sticky", {31'd0, bus.ovf}, 1);
        do_clear(1'b0);
        check("ovf_cleared", {31'd0, bus.ovf}, 0);

        // random traffic, model compared every cycle
        for (int c = 0; c < 3000; c++) begin
            bus.cmd_clear    = ($urandom_range(0, 59) == 0);
            bus.cmd_start    = ($urandom_range(0, 9) == 0);
            bus.cmd_stop     = ($urandom_range(0, 39) == 0);
            bus.sample_valid = 1'($urandom_range(0, 1));
            bus.sample_in    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                           : {4'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
            bus.rd_ready     = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        idle_inputs();
        guard = 0;
        while (bus.state != 2'd0 && guard < 200) begin
            bus.cmd_stop = (bus.state == 2'd2);
            bus.rd_ready = 1'b1;
            @(negedge clk);
            guard++;
        end
        idle_inputs();
        check("drain_idle", {30'd0, bus.state}, 0);

        // reset in the middle of a dump
        do_clear(1'b0);
        pulse_start();
        send(8'h75);
        send(8'h00);
        stop(1'b0, 8'd0);
        bus.rd_ready = 1'b1;
        guard = 0;
        while (bus.rd_bin != 4'd7 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("mid_dump_reached", {28'd0, bus.rd_bin}, 7);
        check("mid_dump_count7", {24'd0, bus.rd_count}, 1);
        rst_n = 1'b0;
        #1;
        check("mrst_state", {30'd0, bus.state}, 0);
        check("mrst_valid", {31'd0, bus.rd_valid}, 0);
        check("mrst_bin", {28'd0, bus.rd_bin}, 0);
        check("mrst_count", {24'd0, bus.rd_count}, 0);
        check("mrst_ready", {31'd0, bus.sample_ready}, 0);
        check("mrst_ovf", {31'd0, bus.ovf}, 0);
        bus.rd_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        stop(1'b0, 8'd0);
        dump(1'b0);
        for (int i = 0; i < 16; i++) e[i] = 0;
        check_hist("post_reset_zero", e);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hist_ctrl.md
HIST_CTRL -- requirements
Module: hist_ctrl

Interface
REQ-001 CNT_W, 8, width of each bin counter in bits.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 sample_in  input  8  sample value; bin index = sample_in[7:4] (16 bins).
REQ-005 sample_valid  input  1  sample_in is valid this cycle.
REQ-006 sample_ready  output  1  block accepts a sample this cycle.
REQ-007 cmd_start  input  1  single-cycle pulse; begin accumulation.
REQ-008 cmd_stop  input  1  single-cycle pulse; end accumulation and start the dump.
REQ-009 cmd_clear  input  1  single-cycle pulse; zero all bins.
REQ-010 rd_valid  output  1  rd_bin/rd_count are valid.
REQ-011 rd_ready  input  1  consumer accepts the readout word.
REQ-012 rd_bin  output  4  bin index being read out.
REQ-013 rd_count  output  CNT_W  count of rd_bin.
REQ-014 state  output  2  FSM state: 0 IDLE, 1 CLEAR, 2 ACCUM, 3 DUMP.
REQ-015 ovf  output  1  sticky flag; a bin reached its maximum count and received another hit.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, CLEAR, ACCUM, DUMP.
REQ-017 Commands in IDLE SHALL be handled as follows: cmd_clear -> CLEAR; otherwise cmd_start -> ACCUM; if both are asserted, cmd_clear wins and cmd_start is dropped.
REQ-018 Commands SHALL be ignored in any state other than the one named in REQ-017, REQ-019 and REQ-021.
REQ-019 CLEAR SHALL zero one bin per cycle (0..15), take 16 cycles, clear ovf, then return to IDLE.
REQ-020 sample_ready SHALL be 1 only in ACCUM.
REQ-021 In ACCUM, cmd_stop SHALL cause a transition to DUMP on the next edge.
REQ-022 In ACCUM, each cycle with sample_valid=1 SHALL increment bin[sample_in[7:4]] by 1 at the next edge.
REQ-023 A sample accepted in the same cycle as cmd_stop SHALL still be counted.
REQ-024 Back-to-back samples to the same bin SHALL each be counted; no hits are lost at one sample per cycle.
REQ-025 In DUMP, rd_valid SHALL be 1, with rd_bin starting at 0 and rd_count equal to that bin's current count.
REQ-026 rd_bin SHALL advance only on a cycle with rd_valid=1 and rd_ready=1; rd_bin, rd_count and rd_valid SHALL hold stable while rd_ready=0.
REQ-027 After bin 15 is transferred, the FSM SHALL go to IDLE and drop rd_valid the next cycle.
REQ-028 Bins SHALL retain their values through DUMP and IDLE.
REQ-029 A new cmd_start without a cmd_clear SHALL continue accumulating on top of the existing counts.
REQ-030 ovf SHALL set on any hit to a bin already at 2^CNT_W-1, and SHALL clear only in CLEAR or on reset.
REQ-031 Outside DUMP, rd_bin and rd_count SHALL be 0.

Reset
REQ-032 On rst_n=0, the block SHALL asynchronously force: state IDLE, all bins 0, ovf 0, rd_valid 0, rd_bin 0, rd_count 0, sample_ready 0.
REQ-033 Reset asserted mid-CLEAR, mid-ACCUM or mid-DUMP SHALL abort the operation with no partial state surviving.
REQ-034 Operation SHALL resume on the first clk edge after rst_n deasserts.

Configuration
REQ-035 With HIST_SAT_EN defined, a bin at 2^CNT_W-1 SHALL hold that value on a further hit (saturating).
REQ-036 With HIST_SAT_EN undefined, a bin at 2^CNT_W-1 SHALL wrap to 0 on a further hit.
REQ-037 ovf SHALL behave per REQ-030 in both builds.

Verification
REQ-038 Clear: reset, cmd_clear -> state=1 for 16 cycles, then state=0; dump shows all 16 counts = 0.
REQ-039 Basic histogram: cmd_start, samples 0x05, 0x13, 0x1F, 0xF0, cmd_stop, rd_ready=1 -> bin0=1, bin1=2, bin15=1, all others 0; rd_valid low after 16 words.
REQ-040 Stop boundary: sample 0x20 with sample_valid=1 in the same cycle as cmd_stop -> bin2=1.
REQ-041 Backpressure: rd_ready toggled 1/0 randomly during the dump -> exactly 16 transfers, rd_bin 0..15 in order, no duplicates, outputs stable while stalled.
REQ-042 Overflow: 257 hits of 0x30 -> bin3=255 and ovf=1 with HIST_SAT_EN defined; bin3=1 and ovf=1 with it undefined.
REQ-043 Reset mid-DUMP at rd_bin=7 -> all outputs 0 and state=0 immediately; a following dump shows all bins 0.
